// File: rtl/ex_mem_skid_reg.sv
// Elastic EX/MEM pipeline register: valid/ready handshake with a two-entry skid buffer and flush.
// Define EX_MEM_FWD_EN to add the head-entry forwarding tap (Fwd_* ports).
module ex_mem_skid_reg #(
    parameter int N          = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  RegWrite_in,
    input  logic                  MemtoReg_in,
    input  logic                  MemRead_in,
    input  logic                  MemWrite_in,
    input  logic [N-1:0]          ALU_Result_in,
    input  logic [N-1:0]          RT_data_in,
    input  logic [REG_ADDR_W-1:0] Dest_Reg_in,
    input  logic                  flush_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  RegWrite_out,
    output logic                  MemtoReg_out,
    output logic                  MemRead_out,
    output logic                  MemWrite_out,
    output logic [N-1:0]          ALU_Result_out,
    output logic [N-1:0]          RT_data_out,
    output logic [REG_ADDR_W-1:0] Dest_Reg_out,
`ifdef EX_MEM_FWD_EN
    output logic                  Fwd_RegWrite_out,
    output logic [REG_ADDR_W-1:0] Fwd_Dest_Reg_out,
    output logic [N-1:0]          Fwd_ALU_Result_out,
`endif
    output logic [1:0]            dbg_state_o
);

    // Handshake: a transfer happens on an edge where valid and ready are both 1.
    // in_ready is a register (low only in TWO), so a MEM stall reaches EX one cycle later.
    typedef struct packed {
        logic                  reg_write;
        logic                  mem_to_reg;
        logic                  mem_read;
        logic                  mem_write;
        logic [N-1:0]          alu;
        logic [N-1:0]          rt;
        logic [REG_ADDR_W-1:0] dest;
    } ent_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t state_q, state_d;
    ent_t   h_q, h_d, s_q, s_d, in_ent;
    logic   in_ready_q, out_valid_q;
    logic   accept, pop;

    assign in_ent = '{reg_write:  RegWrite_in,
                      mem_to_reg: MemtoReg_in,
                      mem_read:   MemRead_in,
                      mem_write:  MemWrite_in,
                      alu:        ALU_Result_in,
                      rt:         RT_data_in,
                      dest:       Dest_Reg_in};

    assign accept = in_valid & in_ready_q;
    assign pop    = out_valid_q & out_ready;

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        s_d     = s_q;
        if (flush_in) begin
            // A pop this cycle still completes; everything else is dropped.
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        h_d     = in_ent;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && pop) begin
                        h_d = in_ent;
                    end else if (accept) begin
                        s_d     = in_ent;
                        state_d = ST_TWO;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        h_d     = s_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

`ifdef EX_MEM_FWD_EN
    logic fwd_we_q;
`endif

    always_ff @(posedge clk) begin
        if (!reset_in) begin
            state_q     <= ST_EMPTY;
            h_q         <= '0;
            s_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef EX_MEM_FWD_EN
            fwd_we_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            s_q         <= s_d;
            in_ready_q  <= (state_d != ST_TWO);
            out_valid_q <= (state_d != ST_EMPTY);
`ifdef EX_MEM_FWD_EN
            fwd_we_q    <= (state_d != ST_EMPTY) & h_d.reg_write & (h_d.dest != '0);
`endif
        end
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = out_valid_q;
    assign RegWrite_out   = h_q.reg_write  & out_valid_q;
    assign MemtoReg_out   = h_q.mem_to_reg & out_valid_q;
    assign MemRead_out    = h_q.mem_read   & out_valid_q;
    assign MemWrite_out   = h_q.mem_write  & out_valid_q;
    // Data fields of an invalid head keep their last value; only controls are gated.
    assign ALU_Result_out = h_q.alu;
    assign RT_data_out    = h_q.rt;
    assign Dest_Reg_out   = h_q.dest;
    assign dbg_state_o    = state_q;

`ifdef EX_MEM_FWD_EN
    assign Fwd_RegWrite_out   = fwd_we_q;
    assign Fwd_Dest_Reg_out   = h_q.dest & {REG_ADDR_W{fwd_we_q}};
    assign Fwd_ALU_Result_out = h_q.alu  & {N{fwd_we_q}};
`endif

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Self-checking bench for ex_mem_skid_reg: directed scenarios plus randomized traffic
// compared every cycle against a queue-based reference model of the two-entry buffer.
module tb_ex_mem_skid_reg;

    localparam int N  = 32;
    localparam int RW = 5;
    localparam int EW = 4 + 2 * N + RW;

    logic          clk = 1'b0;
    logic          reset_in;
    logic          in_valid;
    logic          in_ready;
    logic          RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in;
    logic [N-1:0]  ALU_Result_in, RT_data_in;
    logic [RW-1:0] Dest_Reg_in;
    logic          flush_in;
    logic          out_valid;
    logic          out_ready;
    logic          RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out;
    logic [N-1:0]  ALU_Result_out, RT_data_out;
    logic [RW-1:0] Dest_Reg_out;
    logic [1:0]    dbg_state;
`ifdef EX_MEM_FWD_EN
    logic          Fwd_RegWrite_out;
    logic [RW-1:0] Fwd_Dest_Reg_out;
    logic [N-1:0]  Fwd_ALU_Result_out;
`endif

    ex_mem_skid_reg #(.N(N), .REG_ADDR_W(RW)) dut (
        .clk(clk), .reset_in(reset_in),
        .in_valid(in_valid), .in_ready(in_ready),
        .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in),
        .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
        .ALU_Result_in(ALU_Result_in), .RT_data_in(RT_data_in),
        .Dest_Reg_in(Dest_Reg_in), .flush_in(flush_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out),
        .MemRead_out(MemRead_out), .MemWrite_out(MemWrite_out),
        .ALU_Result_out(ALU_Result_out), .RT_data_out(RT_data_out),
        .Dest_Reg_out(Dest_Reg_out),
`ifdef EX_MEM_FWD_EN
        .Fwd_RegWrite_out(Fwd_RegWrite_out),
        .Fwd_Dest_Reg_out(Fwd_Dest_Reg_out),
        .Fwd_ALU_Result_out(Fwd_ALU_Result_out),
`endif
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    // Reference model: instructions held, oldest first (at most two); plus the last head shown.
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] last_head;
    logic          hs_last;
    int            n_checks = 0;
    int            n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [EW-1:0] in_entry();
        return {RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in,
                ALU_Result_in, RT_data_in, Dest_Reg_in};
    endfunction

    task automatic drive(input logic [3:0] ctrl, input logic [N-1:0] alu,
                         input logic [N-1:0] rt, input logic [RW-1:0] dest);
        in_valid = 1'b1;
        {RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in} = ctrl;
        ALU_Result_in = alu;
        RT_data_in    = rt;
        Dest_Reg_in   = dest;
    endtask

    task automatic drive_rand();
        drive(4'($urandom_range(0, 15)), N'($urandom), N'($urandom), RW'($urandom_range(0, 31)));
    endtask

    // One clock: update the model from the inputs seen at the edge, then compare all outputs.
    task automatic step();
        logic          acc, pop;
        logic [EW-1:0] h;
        logic          hv;
        logic [3:0]    exp_ctrl;
        @(posedge clk);
        acc = in_valid && (exp_q.size() < 2);
        pop = (exp_q.size() > 0) && out_ready;
        hs_last = acc;
        if (!reset_in) begin
            exp_q.delete();
            last_head = '0;
        end else if (flush_in) begin
            exp_q.delete();
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(in_entry());
        end
        if (exp_q.size() > 0) last_head = exp_q[0];
        #1;
        hv = (exp_q.size() > 0);
        h  = last_head;
        exp_ctrl = hv ? h[EW-1 -: 4] : 4'b0;
        check("out_valid", 64'(out_valid), 64'(hv));
        check("in_ready",  64'(in_ready),  64'(exp_q.size() < 2));
        check("ctrl", 64'({RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out}), 64'(exp_ctrl));
        check("alu",  64'(ALU_Result_out), 64'(h[RW+N +: N]));
        check("rt",   64'(RT_data_out),    64'(h[RW +: N]));
        check("dest", 64'(Dest_Reg_out),   64'(h[RW-1:0]));
`ifdef EX_MEM_FWD_EN
        begin
            logic fw;
            fw = hv && h[EW-1] && (h[RW-1:0] != '0);
            check("fwd_we",   64'(Fwd_RegWrite_out),   64'(fw));
            check("fwd_dest", 64'(Fwd_Dest_Reg_out),   fw ? 64'(h[RW-1:0]) : 64'd0);
            check("fwd_alu",  64'(Fwd_ALU_Result_out), fw ? 64'(h[RW+N +: N]) : 64'd0);
        end
`endif
    endtask

    initial begin
        last_head = '0;
        hs_last   = 1'b0;
        reset_in  = 1'b0;
        flush_in  = 1'b0;
        out_ready = 1'b0;
        drive(4'hF, 32'hDEAD, 32'hBEEF, 5'd7);

        // Reset held two cycles with in_valid high.
        step();
        step();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_alu",       64'(ALU_Result_out), 64'd0);
        reset_in = 1'b1;
        in_valid = 1'b0;
        step();

        // Streaming with MEM always ready.
        out_ready = 1'b1;
        drive(4'b1000, 32'h9, 32'h3, 5'd5);
        step();
        check("str_alu0", 64'(ALU_Result_out), 64'h9);
        check("str_rt0",  64'(RT_data_out),    64'h3);
        check("str_dst0", 64'(Dest_Reg_out),   64'd5);
        check("str_rw0",  64'(RegWrite_out),   64'd1);
        drive(4'b1000, 32'hA, 32'h3, 5'd5);
        step();
        check("str_alu1", 64'(ALU_Result_out), 64'hA);
        check("str_rdy",  64'(in_ready),       64'd1);
        in_valid = 1'b0;
        step();

        // Stall and skid: third instruction refused and held by the source.
        out_ready = 1'b0;
        drive(4'b1000, 32'h11, 32'h1, 5'd1);
        step();
        drive(4'b1000, 32'h22, 32'h2, 5'd2);
        step();
        check("skid_rdy0", 64'(in_ready), 64'd0);
        drive(4'b1000, 32'h33, 32'h3, 5'd3);
        step();
        check("skid_h11", 64'(ALU_Result_out), 64'h11);
        out_ready = 1'b1;
        step();
        check("skid_h22", 64'(ALU_Result_out), 64'h22);
        check("skid_rdy1", 64'(in_ready), 64'd1);
        step();
        check("skid_h33", 64'(ALU_Result_out), 64'h33);
        in_valid = 1'b0;
        step();
        check("skid_empty", 64'(out_valid), 64'd0);

        // Flush while full with a new instruction offered.
        out_ready = 1'b0;
        drive(4'b1111, 32'h44, 32'h4, 5'd4);
        step();
        drive(4'b1111, 32'h55, 32'h5, 5'd5);
        step();
        drive(4'b1111, 32'h66, 32'h6, 5'd6);
        flush_in = 1'b1;
        step();
        check("fl_valid", 64'(out_valid), 64'd0);
        check("fl_ctrl", 64'({RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out}), 64'd0);
        flush_in = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        check("fl_gone", 64'(out_valid), 64'd0);

        // Reset in the middle of a stall.
        out_ready = 1'b0;
        drive(4'b1010, 32'h77, 32'h7, 5'd7);
        step();
        drive(4'b1010, 32'h88, 32'h8, 5'd8);
        step();
        in_valid = 1'b0;
        reset_in = 1'b0;
        step();
        check("mr_rdy",   64'(in_ready),  64'd1);
        check("mr_valid", 64'(out_valid), 64'd0);
        check("mr_alu",   64'(ALU_Result_out), 64'd0);
        reset_in = 1'b1;
        step();

`ifdef EX_MEM_FWD_EN
        out_ready = 1'b0;
        drive(4'b1000, 32'h1234, 32'h0, 5'd0);
        step();
        check("fwd_r0", 64'(Fwd_RegWrite_out), 64'd0);
        out_ready = 1'b1;
        drive(4'b1000, 32'hBEEF, 32'h0, 5'd8);
        step();
        check("fwd_we8",  64'(Fwd_RegWrite_out),   64'd1);
        check("fwd_d8",   64'(Fwd_Dest_Reg_out),   64'd8);
        check("fwd_beef", 64'(Fwd_ALU_Result_out), 64'hBEEF);
        in_valid = 1'b0;
        step();
`endif

        // Randomized traffic; a refused instruction stays on the inputs until taken.
        for (int i = 0; i < 800; i++) begin
            if (!(in_valid && !hs_last)) begin
                if ($urandom_range(0, 3) != 0) drive_rand();
                else in_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 2) != 0);
            flush_in  = ($urandom_range(0, 24) == 0);
            reset_in  = ($urandom_range(0, 59) != 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ex_mem_skid_reg.md
# ex_mem_skid_reg

Parametrised, elastic EX/MEM pipeline register for the 32-bit MIPS pipeline, replacing the fixed-width always-load EX/MEM latch. It carries the EX-stage control bits, ALU result, RT store data and destination register into MEM. A valid/ready handshake with a two-entry skid buffer lets MEM stall without combinational ready paths back into EX, and a flush input squashes wrong-path instructions. An optional forwarding tap exposes the head entry to the hazard unit.

## Interface
Parameters:
- `N`, 32, datapath width of `ALU_Result` and `RT_data`
- `REG_ADDR_W`, 5, destination register index width

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `reset_in`  in  1  synchronous, active-low reset
- `in_valid`  in  1  EX presents an instruction this cycle
- `in_ready`  out  1  register can accept; registered, not combinational from `out_ready`
- `RegWrite_in`, `MemtoReg_in`, `MemRead_in`, `MemWrite_in`  in  1 each  EX control bits
- `ALU_Result_in`  in  N  ALU result or memory address
- `RT_data_in`  in  N  store data
- `Dest_Reg_in`  in  REG_ADDR_W  write-back register index
- `flush_in`  in  1  squash all held and incoming instructions
- `out_valid`  out  1  head entry valid toward MEM
- `out_ready`  in  1  MEM consumes head this cycle
- `RegWrite_out`, `MemtoReg_out`, `MemRead_out`, `MemWrite_out`  out  1 each  head control bits, forced 0 when `out_valid`=0
- `ALU_Result_out`, `RT_data_out`  out  N  head data
- `Dest_Reg_out`  out  REG_ADDR_W  head destination
- `Fwd_RegWrite_out`  out  1  forwarding-tap write enable (EX_MEM_FWD_EN only)
- `Fwd_Dest_Reg_out`  out  REG_ADDR_W  forwarding-tap destination (EX_MEM_FWD_EN only)
- `Fwd_ALU_Result_out`  out  N  forwarding-tap value (EX_MEM_FWD_EN only)

## Operation
- Storage: head entry H and skid entry S, each with a valid bit, 4 control bits, two N-bit data fields and a destination field.
- States: EMPTY (H, S invalid), ONE (H valid), TWO (H and S valid).
- Accept = `in_valid & in_ready`. Pop = `out_valid & out_ready`.
- EMPTY: accept → ONE, H loads input.
- ONE: accept without pop → TWO, S loads input. Pop without accept → EMPTY. Accept and pop → ONE, H loads input.
- TWO: `in_ready`=0. Pop → ONE, H loads S.
- `in_ready` = state != TWO.
- `out_valid` = H valid.
- Flush (`flush_in`=1, `reset_in`=1): next state EMPTY, and any accept that cycle is dropped. A pop in the same cycle still completes: MEM sees the head, then it is discarded.
- Reset (`reset_in`=0 at the edge): EMPTY, all data, control and destination fields cleared to 0. Reset overrides flush, accept and pop, including mid-stall in TWO.
- Data fields of an invalid H hold their last value. Only the control outputs are gated.
- No arithmetic; all fields pass through unmodified.

## Timing
- Latency: input accepted at edge k appears on outputs after edge k (one cycle) when the register was EMPTY, or ONE with a pop.
- Throughput: one instruction per cycle while `out_ready`=1.
- Stall propagation: `in_ready` deasserts one cycle after the stall, never combinationally in the same cycle.
- Reset values: `out_valid`=0, `in_ready`=1, all control outputs 0, `ALU_Result_out`=0, `RT_data_out`=0, `Dest_Reg_out`=0, all Fwd outputs 0.
- All outputs are registered or a single AND gate off registers.

## Configuration
- `EX_MEM_FWD_EN` defined: Fwd ports present.
  - `Fwd_RegWrite_out` = H valid & H.RegWrite & (H.Dest != 0).
  - `Fwd_Dest_Reg_out` and `Fwd_ALU_Result_out` = H fields when `Fwd_RegWrite_out`=1, otherwise 0.
  - The S entry is never forwarded.
- `EX_MEM_FWD_EN` undefined: Fwd ports and logic absent. The hazard unit uses `Dest_Reg_out` and `RegWrite_out` directly.

## Test plan
- Reset: hold `reset_in`=0 for 2 cycles with `in_valid`=1 → `out_valid`=0, `in_ready`=1, `ALU_Result_out`=0.
- Stream: `out_ready`=1; inject ALU=0x9, RT=0x3, RegWrite=1, Dest=5, then ALU=0xA → values appear one cycle later in order, `in_ready` stays 1.
- Stall/skid: `out_ready`=0; inject 0x11, 0x22, 0x33 back-to-back → 0x11 in H, 0x22 in S, `in_ready`=0, 0x33 refused and held by source. Release `out_ready` → 0x11, 0x22, 0x33 delivered with no loss or duplication.
- Flush in TWO with simultaneous `in_valid` → next cycle `out_valid`=0, all control outputs 0, incoming instruction never appears.
- Mid-stall reset: in TWO, drive `reset_in`=0 → EMPTY, `in_ready`=1 at the next cycle.
- Forwarding (EX_MEM_FWD_EN): H holds RegWrite=1, Dest=0 → `Fwd_RegWrite_out`=0. H holds Dest=8, ALU=0xBEEF → Fwd outputs 1/8/0xBEEF.
